// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared constants and arithmetic helpers for the filter chain stages
package dsp_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int MAX_W      = 32;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < value) r++;
      end
      return r;
   endfunction

   // Round-half-up arithmetic shift; caller sign-extends into MAX_W and truncates to its width
   function automatic logic signed [MAX_W-1:0] round_shift(input logic signed [MAX_W-1:0] sum,
                                                           input int shift);
      logic signed [MAX_W-1:0] half;
      half = '0;
      if (shift > 0) half = MAX_W'(1) << (shift - 1);
      return (sum + half) >>> shift;
   endfunction

endpackage

// File: rtl/fir_decimator_if.sv
// rtl/fir_decimator_if.sv - sample input and decimated output handshake bundle
interface fir_decimator_if #(
   parameter int DATA_W = dsp_pkg::DATA_W_DEF
);
   logic                     in_valid;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic signed [DATA_W-1:0] out_data;

   modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
   modport slave  (input in_valid, in_data, out_ready, output out_valid, out_data);
endinterface

// File: rtl/fir_decimator_sync_fifo.sv
// rtl/fir_decimator_sync_fifo.sv - show-ahead synchronous FIFO with flush, push accepted when full if popping
module sync_fifo
   import dsp_pkg::*;
#(
   parameter int  DATA_W = DATA_W_DEF,
   parameter int  DEPTH  = 4,
   localparam int AW     = clog2(DEPTH),
   localparam int CNT_W  = AW + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              full,
   output logic              empty,
   output logic [CNT_W-1:0]  count
);
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(DEPTH));
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign head_data = mem[rd_ptr];

   // Storage is cleared too so the head reads zero after reset or flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - integrate-and-dump decimator with rounding and an output FIFO
module fir_decimator
   import dsp_pkg::*;
#(
   parameter int  DATA_W     = DATA_W_DEF,
   parameter int  DECIM      = 4,
   parameter int  FIFO_DEPTH = 4,
   localparam int SHIFT      = clog2(DECIM),
   localparam int ACC_W      = DATA_W + SHIFT,
   localparam int CNT_W      = clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   fir_decimator_if.slave   bus,
   output logic [CNT_W-1:0] fifo_count,
   output logic             overflow
);
   logic [SHIFT-1:0]        phase;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;
   logic [DATA_W-1:0]       result;
   logic                    last_phase;
   logic                    dump;
   logic                    pop_fire;
   logic                    fifo_full;
   logic                    fifo_empty;

   assign sum        = acc + {{SHIFT{bus.in_data[DATA_W-1]}}, bus.in_data};
   assign result     = DATA_W'(round_shift(MAX_W'(sum), SHIFT));
   assign last_phase = (phase == SHIFT'(DECIM - 1));
   assign dump       = bus.in_valid & last_phase & ~clr;
   assign pop_fire   = bus.out_valid & bus.out_ready;
   assign bus.out_valid = ~fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase    <= '0;
         acc      <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         phase    <= '0;
         acc      <= '0;
         overflow <= 1'b0;
      end else begin
         if (bus.in_valid) begin
            if (last_phase) begin
               acc   <= '0;
               phase <= '0;
            end else begin
               acc   <= sum;
               phase <= phase + SHIFT'(1);
            end
         end
         // A dump into a full FIFO only survives when the head leaves on the same edge
         if (dump & fifo_full & ~pop_fire) overflow <= 1'b1;
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .push      (dump),
      .push_data (result),
      .pop       (bus.out_ready),
      .head_data (bus.out_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - randomized scoreboard bench for the decimator and its output FIFO
module tb_fir_decimator;
   localparam int DATA_W = 16;
   localparam int DECIM  = 4;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = 3;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b1;
   logic             clr   = 1'b0;
   logic [CNT_W-1:0] fifo_count;
   logic             overflow;

   fir_decimator_if #(.DATA_W(DATA_W)) bus();

   fir_decimator #(
      .DATA_W     (DATA_W),
      .DECIM      (DECIM),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .bus        (bus),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int m_q[$];
   int m_sum = 0;
   int m_n   = 0;
   bit m_ovf = 1'b0;

   // Block average with round-half-up, using floor division on the true sum
   function automatic int avg_round(input int s);
      int n;
      int q;
      n = s + DECIM / 2;
      q = n / DECIM;
      if (n < 0 && (n % DECIM) != 0) q = q - 1;
      return q;
   endfunction

   task automatic model_clear();
      m_q.delete();
      m_sum = 0;
      m_n   = 0;
      m_ovf = 1'b0;
   endtask

   task automatic cycle(input bit v, input int d);
      bit popped;
      bus.in_valid = v;
      bus.in_data  = DATA_W'(d);
      tests++;
      if (bus.out_valid !== (m_q.size() != 0)) begin
         fails++;
         $display("FAIL mon_out_valid: got %0b exp %0b", bus.out_valid, m_q.size() != 0);
      end
      if (m_q.size() != 0) begin
         tests++;
         if (bus.out_data !== DATA_W'(m_q[0])) begin
            fails++;
            $display("FAIL mon_out_data: got %0d exp %0d", bus.out_data, m_q[0]);
         end
      end
      tests++;
      if (fifo_count !== CNT_W'(m_q.size()) || overflow !== m_ovf) begin
         fails++;
         $display("FAIL mon_count_ovf: got %0d/%0b exp %0d/%0b", fifo_count, overflow, m_q.size(), m_ovf);
      end
      if (clr) begin
         model_clear();
      end else begin
         popped = bus.out_ready && (m_q.size() != 0);
         if (popped) void'(m_q.pop_front());
         if (v) begin
            m_sum += d;
            m_n++;
            if (m_n == DECIM) begin
               if (m_q.size() < DEPTH) m_q.push_back(avg_round(m_sum));
               else m_ovf = 1'b1;
               m_sum = 0;
               m_n   = 0;
            end
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic block(input int a, input int b, input int c, input int e);
      cycle(1'b1, a);
      cycle(1'b1, b);
      cycle(1'b1, c);
      cycle(1'b1, e);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || fifo_count !== '0 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: got v=%0b d=%0d c=%0d o=%0b exp all zero",
                  bus.out_valid, bus.out_data, fifo_count, overflow);
      end
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      apply_reset();
   endtask

   task automatic test_single_block();
      bus.out_ready = 1'b1;
      block(100, 100, 100, 100);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd100) begin
         fails++;
         $display("FAIL single_block: got v=%0b d=%0d exp v=1 d=100", bus.out_valid, bus.out_data);
      end
      cycle(1'b0, 0);
      tests++;
      if (bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL single_block_pulse: got v=%0b exp 0", bus.out_valid);
      end
   endtask

   task automatic test_rounding();
      int blk [6][4] = '{'{1, 1, 0, 0}, '{1, 0, 0, 0}, '{-1, -1, 0, 0}, '{-3, 0, 0, 0},
                         '{32767, 32767, 32767, 32767}, '{-32768, -32768, -32768, -32768}};
      int expv [6] = '{1, 0, 0, -1, 32767, -32768};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         block(blk[i][0], blk[i][1], blk[i][2], blk[i][3]);
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== DATA_W'(expv[i])) begin
            fails++;
            $display("FAIL rounding_%0d: got v=%0b d=%0d exp %0d", i, bus.out_valid, bus.out_data, expv[i]);
         end
         cycle(1'b0, 0);
      end
   endtask

   task automatic test_gapped();
      int smp [4] = '{10, 20, 30, 40};
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 3)) cycle(1'b0, 0);
         if (i == 3) begin
            tests++;
            if (bus.out_valid !== 1'b0 || fifo_count !== '0) begin
               fails++;
               $display("FAIL gapped_early: got v=%0b c=%0d exp 0/0", bus.out_valid, fifo_count);
            end
         end
         cycle(1'b1, smp[i]);
      end
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd25) begin
         fails++;
         $display("FAIL gapped: got v=%0b d=%0d exp 25", bus.out_valid, bus.out_data);
      end
      cycle(1'b0, 0);
   endtask

   task automatic test_overflow();
      bus.out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) block(k, k, k, k);
      tests++;
      if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL overflow_full: got c=%0d o=%0b exp 4/1", fifo_count, overflow);
      end
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tests++;
         if (bus.out_valid !== 1'b1 || bus.out_data !== DATA_W'(k)) begin
            fails++;
            $display("FAIL overflow_drain: got v=%0b d=%0d exp %0d", bus.out_valid, bus.out_data, k);
         end
         cycle(1'b0, 0);
      end
      tests++;
      if (bus.out_valid !== 1'b0 || overflow !== 1'b1) begin
         fails++;
         $display("FAIL overflow_after: got v=%0b o=%0b exp 0/1", bus.out_valid, overflow);
      end
      apply_reset();
   endtask

   task automatic test_full_pop();
      int expv [4] = '{11, 12, 13, 20};
      bus.out_ready = 1'b0;
      for (int k = 10; k <= 13; k++) block(k, k, k, k);
      cycle(1'b1, 20);
      cycle(1'b1, 20);
      cycle(1'b1, 20);
      bus.out_ready = 1'b1;
      cycle(1'b1, 20);
      bus.out_ready = 1'b0;
      tests++;
      if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL full_pop: got c=%0d o=%0b exp 4/0", fifo_count, overflow);
      end
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (bus.out_data !== DATA_W'(expv[i])) begin
            fails++;
            $display("FAIL full_pop_drain: got %0d exp %0d", bus.out_data, expv[i]);
         end
         cycle(1'b0, 0);
      end
   endtask

   task automatic test_clear_mid_block();
      bus.out_ready = 1'b1;
      cycle(1'b1, 1000);
      cycle(1'b1, 1000);
      apply_reset();
      block(8, 8, 8, 8);
      tests++;
      if (bus.out_data !== 16'sd8 || bus.out_valid !== 1'b1) begin
         fails++;
         $display("FAIL reset_mid_block: got v=%0b d=%0d exp 8", bus.out_valid, bus.out_data);
      end
      cycle(1'b0, 0);
      bus.out_ready = 1'b0;
      for (int k = 0; k < 5; k++) block(7, 7, 7, 7);
      cycle(1'b1, 1000);
      cycle(1'b1, 1000);
      clr = 1'b1;
      cycle(1'b1, 1000);
      clr = 1'b0;
      tests++;
      if (fifo_count !== '0 || overflow !== 1'b0 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL clr_state: got c=%0d o=%0b v=%0b exp 0/0/0", fifo_count, overflow, bus.out_valid);
      end
      bus.out_ready = 1'b1;
      block(8, 8, 8, 8);
      tests++;
      if (bus.out_data !== 16'sd8 || bus.out_valid !== 1'b1) begin
         fails++;
         $display("FAIL clr_mid_block: got v=%0b d=%0d exp 8", bus.out_valid, bus.out_data);
      end
      cycle(1'b0, 0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         bus.out_ready = ($urandom_range(0, 3) == 0);
         clr = ($urandom_range(0, 150) == 0);
         cycle($urandom_range(0, 2) != 0, $urandom_range(0, 65535) - 32768);
         clr = 1'b0;
      end
      bus.out_ready = 1'b1;
      repeat (6) cycle(1'b0, 0);
      tests++;
      if (fifo_count !== '0 || bus.out_valid !== 1'b0) begin
         fails++;
         $display("FAIL random_drain: got c=%0d v=%0b exp 0/0", fifo_count, bus.out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_rounding();
      test_gapped();
      test_overflow();
      test_full_pop();
      test_clear_mid_block();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
